// File: rtl/spi_pkg.sv
// Shared SPI master types and constants.
// Latency: n/a; backpressure: n/a.
package spi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam int SPI_BYTE_BITS = 8;
   localparam int CLK_DIV_DEF   = 4;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK phase generator: idle-low clock plus rise (sample) and bit-end (shift) strobes.
// Latency: strobes are decoded from the phase register; backpressure: none, runs whenever run=1.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic run,
   output logic spi_sclk,
   output logic sample,
   output logic shift
);

   localparam int HALF = CLK_DIV / 2;
   localparam int PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0] phase;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         phase <= '0;
      end else if (!run || phase == PW'(CLK_DIV - 1)) begin
         phase <= '0;
      end else begin
         phase <= phase + PW'(1);
      end
   end

   // sample lands on the edge where SCLK rises; shift on the edge where it falls
   assign spi_sclk = run && (phase >= PW'(HALF));
   assign sample   = run && (phase == PW'(HALF - 1));
   assign shift    = run && (phase == PW'(CLK_DIV - 1));

endmodule

// File: rtl/spi_drive.sv
// SPI mode-0 master, MSB first, back-to-back 8-bit frames inside one CS-low session.
// Latency: 8*CLK_DIV cycles per byte plus one completion cycle; backpressure: none, user must track send_done.
module spi_drive
   import spi_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       spi_start,
   input  logic       spi_end,
   input  logic [7:0] data_send,
   output logic [7:0] data_rec,
   output logic       send_done,
   output logic       rec_done,
   input  logic       spi_miso,
   output logic       spi_sclk,
   output logic       spi_cs,
   output logic       spi_mosi
);

   state_t                   state, state_nxt;
   logic [SPI_BYTE_BITS-1:0] tx_sr;
   logic [SPI_BYTE_BITS-1:0] rx_sr;
   logic [2:0]               bit_cnt;
   logic                     cmpl;
   logic                     end_pend;
   logic                     run;
   logic                     sample;
   logic                     shift;
   logic                     last_bit;
   logic                     close;

   assign run      = (state == XFER) && !cmpl;
   assign last_bit = (bit_cnt == 3'(SPI_BYTE_BITS - 1));
   assign close    = cmpl && (end_pend || spi_end);
   assign spi_mosi = tx_sr[SPI_BYTE_BITS-1];

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .run      (run),
      .spi_sclk (spi_sclk),
      .sample   (sample),
      .shift    (shift)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (spi_start) state_nxt = XFER;
         XFER:    if (close)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         spi_cs    <= 1'b1;
         tx_sr     <= '0;
         rx_sr     <= '0;
         bit_cnt   <= '0;
         cmpl      <= 1'b0;
         end_pend  <= 1'b0;
         data_rec  <= '0;
         send_done <= 1'b0;
         rec_done  <= 1'b0;
      end else begin
         send_done <= 1'b0;
         rec_done  <= 1'b0;
         if (state == IDLE) begin
            if (spi_start) begin
               spi_cs   <= 1'b0;
               tx_sr    <= data_send;
               bit_cnt  <= '0;
               cmpl     <= 1'b0;
               end_pend <= 1'b0;
            end
         end else begin
            if (spi_end) end_pend <= 1'b1;
            if (cmpl) begin
               // completion cycle: either close the session or roll straight into the next byte
               cmpl <= 1'b0;
               if (close) begin
                  spi_cs   <= 1'b1;
                  tx_sr    <= '0;
                  end_pend <= 1'b0;
               end else begin
                  tx_sr   <= data_send;
                  bit_cnt <= '0;
               end
            end else begin
               if (sample) rx_sr <= {rx_sr[SPI_BYTE_BITS-2:0], spi_miso};
               if (shift) begin
                  if (last_bit) begin
                     cmpl      <= 1'b1;
                     send_done <= 1'b1;
                     rec_done  <= 1'b1;
                     data_rec  <= rx_sr;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx_sr   <= {tx_sr[SPI_BYTE_BITS-2:0], 1'b0};
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_drive.sv
// Directed bench for spi_drive: reset, single/multi byte, loopback, slave pattern, ignored inputs.
module tb_spi_drive;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       spi_start;
   logic       spi_end;
   logic [7:0] data_send;
   logic [7:0] data_rec;
   logic       send_done;
   logic       rec_done;
   logic       spi_miso;
   logic       spi_sclk;
   logic       spi_cs;
   logic       spi_mosi;

   logic       loop_en;
   logic [7:0] slave_pat;
   int         slave_idx;
   int         rise_cnt;
   int         cs_low_cnt;
   int         sd_cnt;
   int         rd_cnt;
   logic [7:0] mosi_bits;
   int         n_assert = 0;
   int         n_fail   = 0;
   int         lat;

   always #5 sys_clk = ~sys_clk;

   assign spi_miso = loop_en ? spi_mosi : slave_pat[3'(7 - slave_idx)];

   spi_drive #(.CLK_DIV(4)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .spi_start (spi_start),
      .spi_end   (spi_end),
      .data_send (data_send),
      .data_rec  (data_rec),
      .send_done (send_done),
      .rec_done  (rec_done),
      .spi_miso  (spi_miso),
      .spi_sclk  (spi_sclk),
      .spi_cs    (spi_cs),
      .spi_mosi  (spi_mosi)
   );

   always @(posedge spi_sclk) begin
      rise_cnt  = rise_cnt + 1;
      mosi_bits = {mosi_bits[6:0], spi_mosi};
   end

   always @(negedge spi_sclk) slave_idx = slave_idx + 1;

   always @(posedge sys_clk) begin
      if (spi_cs === 1'b0) cs_low_cnt = cs_low_cnt + 1;
      if (send_done === 1'b1) sd_cnt = sd_cnt + 1;
      if (rec_done === 1'b1) rd_cnt = rd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      rise_cnt   = 0;
      cs_low_cnt = 0;
      sd_cnt     = 0;
      rd_cnt     = 0;
      mosi_bits  = 8'h00;
   endtask

   task automatic start_byte(input logic [7:0] d);
      data_send = d;
      spi_start = 1'b1;
      @(negedge sys_clk);
      spi_start = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (send_done !== 1'b1 && cycles < 100) begin
         @(negedge sys_clk);
         cycles++;
      end
      chk("done_seen", 32'(send_done), 'h1);
   endtask

   task automatic end_now();
      spi_end = 1'b1;
      @(negedge sys_clk);
      spi_end = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      sys_rst   = 1'b1;
      spi_start = 1'b0;
      spi_end   = 1'b0;
      data_send = 8'h00;
      loop_en   = 1'b0;
      slave_pat = 8'h00;
      slave_idx = 0;
      clr();
      repeat (3) @(negedge sys_clk);
      chk("rst_cs",   32'(spi_cs),    'h1);
      chk("rst_sclk", 32'(spi_sclk),  'h0);
      chk("rst_mosi", 32'(spi_mosi),  'h0);
      chk("rst_rec",  32'(data_rec),  'h00);
      chk("rst_sd",   32'(send_done), 'h0);
      chk("rst_rd",   32'(rec_done),  'h0);
      sys_rst = 1'b0;
      @(negedge sys_clk);

      // single byte 0x55
      clr();
      start_byte(8'h55);
      wait_done(lat);
      chk("t1_lat", lat, 32);
      chk("t1_rd_with_sd", 32'(rec_done), 'h1);
      end_now();
      repeat (3) @(negedge sys_clk);
      chk("t1_cs_high", 32'(spi_cs), 'h1);
      chk("t1_rises", rise_cnt, 8);
      chk("t1_mosi", 32'(mosi_bits), 'h55);
      chk("t1_cs_low", cs_low_cnt, 33);
      chk("t1_sd_cnt", sd_cnt, 1);

      // loopback 0xA3
      loop_en = 1'b1;
      clr();
      start_byte(8'hA3);
      wait_done(lat);
      chk("t2_rec", 32'(data_rec), 'hA3);
      chk("t2_rd", 32'(rec_done), 'h1);
      end_now();
      repeat (3) @(negedge sys_clk);
      chk("t2_rd_cnt", rd_cnt, 1);
      chk("t2_sd_cnt", sd_cnt, 1);
      chk("t2_cs_high", 32'(spi_cs), 'h1);

      // two bytes; start+end together in IDLE must behave as start only
      clr();
      data_send = 8'h12;
      spi_start = 1'b1;
      spi_end   = 1'b1;
      @(negedge sys_clk);
      spi_start = 1'b0;
      spi_end   = 1'b0;
      wait_done(lat);
      chk("t3_lat0", lat, 32);
      chk("t3_rec0", 32'(data_rec), 'h12);
      chk("t3_mosi0", 32'(mosi_bits), 'h12);
      data_send = 8'hF0;
      @(negedge sys_clk);
      chk("t3_cs_between", 32'(spi_cs), 'h0);
      wait_done(lat);
      chk("t3_lat1", lat, 32);
      chk("t3_rec1", 32'(data_rec), 'hF0);
      chk("t3_mosi1", 32'(mosi_bits), 'hF0);
      end_now();
      repeat (3) @(negedge sys_clk);
      chk("t3_rises", rise_cnt, 16);
      chk("t3_sd_cnt", sd_cnt, 2);
      chk("t3_cs_low", cs_low_cnt, 66);
      chk("t3_cs_high", 32'(spi_cs), 'h1);

      // slave drives 1,0,0,1,1,0,1,0
      loop_en   = 1'b0;
      slave_pat = 8'h9A;
      slave_idx = 0;
      clr();
      start_byte(8'h00);
      wait_done(lat);
      chk("t4_rec", 32'(data_rec), 'h9A);
      chk("t4_rd", 32'(rec_done), 'h1);
      end_now();
      repeat (3) @(negedge sys_clk);

      // spi_end in IDLE, then spi_start and data_send changes mid-byte
      clr();
      end_now();
      repeat (8) @(negedge sys_clk);
      chk("t5_idle_cs", 32'(spi_cs), 'h1);
      chk("t5_idle_rises", rise_cnt, 0);
      loop_en = 1'b1;
      start_byte(8'hC3);
      repeat (4) @(negedge sys_clk);
      data_send = 8'h00;
      spi_start = 1'b1;
      @(negedge sys_clk);
      spi_start = 1'b0;
      wait_done(lat);
      chk("t5_lat", lat, 27);
      chk("t5_rec", 32'(data_rec), 'hC3);
      chk("t5_mosi", 32'(mosi_bits), 'hC3);
      chk("t5_rises", rise_cnt, 8);
      end_now();
      repeat (3) @(negedge sys_clk);
      chk("t5_cs_low", cs_low_cnt, 33);
      chk("t5_cs_high", 32'(spi_cs), 'h1);

      // asynchronous reset while SCLK is high mid-byte
      clr();
      start_byte(8'hFF);
      repeat (10) @(negedge sys_clk);
      chk("t6_pre_sclk", 32'(spi_sclk), 'h1);
      chk("t6_pre_cs", 32'(spi_cs), 'h0);
      #2 sys_rst = 1'b1;
      #1;
      chk("t6_cs", 32'(spi_cs), 'h1);
      chk("t6_sclk", 32'(spi_sclk), 'h0);
      chk("t6_mosi", 32'(spi_mosi), 'h0);
      chk("t6_rec", 32'(data_rec), 'h00);
      chk("t6_sd", 32'(send_done), 'h0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("t6_post_cs", 32'(spi_cs), 'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
